// File: rtl/vgaram_arbiter.sv
// Single-port video RAM arbiter: VGA fetch (announced one clock ahead) always wins over the CPU.
// CPU access granted in cycle G, acked in G+1 with read data; CPU waits on o_cpu_ack while VGA owns the RAM.
module vgaram_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int STALL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_vga_access,
    input  logic               i_vga_cs,
    input  logic [AW-1:0]      i_vga_addr,
    output logic [DW-1:0]      o_vga_dat,
    input  logic               i_cpu_cs,
    input  logic               i_cpu_we,
    input  logic [AW-1:0]      i_cpu_addr,
    input  logic [DW-1:0]      i_cpu_dat,
    output logic [DW-1:0]      o_cpu_dat,
    output logic               o_cpu_ack,
    output logic               o_ram_cs,
    output logic               o_ram_we,
    output logic [AW-1:0]      o_ram_addr,
    output logic [DW-1:0]      o_ram_dat,
    input  logic [DW-1:0]      i_ram_dat,
    input  logic               i_stat_clr,
    output logic [STALL_W-1:0] o_stall_cnt,
    output logic               o_err
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic          vga_resv;
    logic          vga_busy;
    logic          cpu_grant;
    logic          cpu_stall;
    logic          rd_pending;
    logic [DW-1:0] dat_reg;

    assign vga_busy  = vga_resv | i_vga_cs;
    assign o_vga_dat = i_ram_dat;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            vga_resv    <= 1'b0;
            rd_pending  <= 1'b0;
            dat_reg     <= '0;
            o_stall_cnt <= '0;
            o_err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            vga_resv <= i_vga_access;
            if (cpu_grant)
                rd_pending <= ~i_cpu_we;
            // RAM is pipelined: data returning in ACK belongs to the CPU grant cycle
            if (state == ACK && rd_pending)
                dat_reg <= i_ram_dat;
            if (i_stat_clr) begin
                o_stall_cnt <= '0;
                o_err       <= 1'b0;
            end else begin
                if (cpu_stall && o_stall_cnt != {STALL_W{1'b1}})
                    o_stall_cnt <= o_stall_cnt + STALL_ONE;
                if (i_vga_cs && !vga_resv)
                    o_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_grant = 1'b0;
        cpu_stall = 1'b0;
        o_cpu_ack = 1'b0;
        o_cpu_dat = dat_reg;
        case (state)
            IDLE: begin
                cpu_grant = i_cpu_cs & ~vga_busy;
                cpu_stall = i_cpu_cs & vga_busy;
                if (cpu_grant)
                    state_nxt = ACK;
            end
            ACK: begin
                o_cpu_ack = 1'b1;
                if (rd_pending)
                    o_cpu_dat = i_ram_dat;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ram_cs   = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_addr = '0;
        o_ram_dat  = '0;
        if (i_vga_cs) begin
            o_ram_cs   = 1'b1;
            o_ram_addr = i_vga_addr;
        end else if (cpu_grant) begin
            o_ram_cs   = 1'b1;
            o_ram_we   = i_cpu_we;
            o_ram_addr = i_cpu_addr;
            o_ram_dat  = i_cpu_dat;
        end
    end

endmodule
